// File: rtl/reset_sequencer_pkg.sv
// Shared types for the staged reset sequencer: FSM states, reset-cause codes and a sizing helper.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD     = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_CPU_DLY  = 2'd2,
      ST_RUN      = 2'd3
   } seq_state_t;

   localparam logic [1:0] CAUSE_POR = 2'b00;
   localparam logic [1:0] CAUSE_BTN = 2'b01;
   localparam logic [1:0] CAUSE_DTR = 2'b10;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low reset to a parameterised value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= {2{RST_VAL}};
      else          r_sync <= {r_sync[0], i_d};
   end

   assign o_q = r_sync[1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: memory released first, CPU after mem_ready (or timeout).
// Optional button debounce enabled by defining RESET_BTN_DEBOUNCE_EN.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int HOLD_CYCLES      = 16,
   parameter int CPU_DELAY_CYCLES = 8,
   parameter int READY_TIMEOUT    = 1024
`ifdef RESET_BTN_DEBOUNCE_EN
   ,
   parameter int DEBOUNCE_CYCLES  = 50000
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       reset_dtr,
   input  logic       btn_n,
   input  logic       mem_ready,
   output logic       reset_mem,
   output logic       reset_cpu,
   output logic [1:0] reset_cause,
   output logic       mem_timeout
);

   localparam int CW = $clog2(max3(HOLD_CYCLES, CPU_DELAY_CYCLES, READY_TIMEOUT) + 1);
   localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CPU_LOAD  = CW'(CPU_DELAY_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(READY_TIMEOUT - 1);

   logic w_rst_n;
   logic w_btn_sync;
   logic w_btn_req;
   logic w_req;

   seq_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_reset_mem;
   logic          r_reset_cpu;
   logic [1:0]    r_cause;
   logic          r_timeout;

   // Reset bridge: asserts asynchronously, releases two edges after reset_n rises.
   sync_2ff #(.RST_VAL(1'b0)) u_rst_sync (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_d     (1'b1),
      .o_q     (w_rst_n)
   );

   sync_2ff #(.RST_VAL(1'b1)) u_btn_sync (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_d     (btn_n),
      .o_q     (w_btn_sync)
   );

`ifdef RESET_BTN_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic [DW-1:0] r_db_cnt;

   // Counts consecutive low samples, saturating one short of the threshold.
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n)                r_db_cnt <= '0;
      else if (w_btn_sync)         r_db_cnt <= '0;
      else if (r_db_cnt != DB_LAST) r_db_cnt <= r_db_cnt + 1'b1;
   end

   assign w_btn_req = !w_btn_sync && (r_db_cnt == DB_LAST);
`else
   assign w_btn_req = !w_btn_sync;
`endif

   assign w_req = w_btn_req | reset_dtr;

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state     <= ST_HOLD;
         r_cnt       <= HOLD_LOAD;
         r_reset_mem <= 1'b1;
         r_reset_cpu <= 1'b1;
         r_cause     <= CAUSE_POR;
         r_timeout   <= 1'b0;
      end else if (w_req) begin
         r_state     <= ST_HOLD;
         r_cnt       <= HOLD_LOAD;
         r_reset_mem <= 1'b1;
         r_reset_cpu <= 1'b1;
         r_cause     <= w_btn_req ? CAUSE_BTN : CAUSE_DTR;
         r_timeout   <= 1'b0;
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (r_cnt == '0) begin
                  r_state     <= ST_WAIT_MEM;
                  r_reset_mem <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_WAIT_MEM: begin
               if (mem_ready) begin
                  r_state <= ST_CPU_DLY;
                  r_cnt   <= CPU_LOAD;
               end else if (r_cnt == TO_LAST) begin
                  r_state   <= ST_CPU_DLY;
                  r_cnt     <= CPU_LOAD;
                  r_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CPU_DLY: begin
               if (r_cnt == '0) begin
                  r_state     <= ST_RUN;
                  r_reset_cpu <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign reset_mem   = r_reset_mem;
   assign reset_cpu   = r_reset_cpu;
   assign reset_cause = r_cause;
   assign mem_timeout = r_timeout;

endmodule
